mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
Initiator-side controller for the synchronous single-port `memory` block (1-cycle registered read, write on `we`).
- Accepts burst read/write commands from the core over a valid/ready interface.
- Drives `memory`'s `we`/`addr`/`data` pins and captures its `out` bus.
- Streams write data in and read data out, each with its own valid/ready handshake.
- Sits between the datapath and the RAM instance; one controller per RAM.

Parameters:
ADDR_WIDTH, 6, memory address width; must match the attached `memory`
DATA_WIDTH, 16, word width; must match the attached `memory`
LEN_WIDTH, 4, burst length field width; beats = cmd_len+1 (1..2^LEN_WIDTH)

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  controller accepts a command (high only in IDLE)
cmd_we  in  1  1 = write burst, 0 = read burst
cmd_addr  in  ADDR_WIDTH  start address
cmd_len  in  LEN_WIDTH  beats minus one
wr_data  in  DATA_WIDTH  write beat data
wr_valid  in  1  write beat present
wr_ready  out  1  controller accepts a write beat
rd_data  out  DATA_WIDTH  read beat data (registered)
rd_valid  out  1  read beat present
rd_ready  in  1  consumer accepts read beat
busy  out  1  burst in progress (state != IDLE)
done  out  1  one-cycle pulse after the last beat completes
mem_we  out  1  to memory.we
mem_addr  out  ADDR_WIDTH  to memory.addr (registered current address)
mem_data  out  DATA_WIDTH  to memory.data
mem_out  in  DATA_WIDTH  from memory.out

Behaviour:
- State encoding and transitions:
  - States: IDLE, WRITE, RD_ISSUE, RD_LAT, RD_OUT.
  - Registers: cur_addr (drives mem_addr), remaining (LEN_WIDTH), rd_data, done.
- Reset (the rst=1 edge wins over everything):
  - state=IDLE, cur_addr=0, remaining=0, rd_data=0, done=0.
  - Outputs after that edge: cmd_ready=1, busy=0, wr_ready=0, rd_valid=0, mem_we=0, mem_data=0.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: load cur_addr=cmd_addr and remaining=cmd_len.
  - Next state is WRITE if cmd_we=1, else RD_ISSUE.
  - Command fields are sampled only on the accept edge; later changes are ignored.
- WRITE:
  - wr_ready=1.
  - mem_we = wr_valid (combinational) and mem_data = wr_data, so the RAM writes mem[cur_addr] on the same edge.
  - On the handshake edge:
    - If remaining==0: IDLE, done=1 next cycle.
    - Otherwise: remaining-1, cur_addr+1.
  - wr_valid=0 stalls indefinitely with mem_we=0.
- Read sequence, at 3 cycles per beat when rd_ready stays high:
  - RD_ISSUE: mem_we=0; mem_addr=cur_addr is sampled by the RAM at the next edge; go to RD_LAT.
  - RD_LAT: mem_out holds mem[cur_addr]; latch rd_data=mem_out; go to RD_OUT.
  - RD_OUT: rd_valid=1.
    - rd_data is held stable until rd_ready.
    - On the handshake edge: if remaining==0, go to IDLE and done=1 next cycle; otherwise remaining-1, cur_addr+1, RD_ISSUE.
- Address arithmetic and bus defaults:
  - cur_addr increments modulo 2^ADDR_WIDTH: 63 → 0 at the defaults, with no error.
  - mem_data=0 outside WRITE.
  - mem_we is never high outside WRITE.
- Command and done rules:
  - cmd_valid while busy is not accepted (cmd_ready=0); the command is held by the source, not dropped by us.
  - done is high for exactly one cycle, coincident with the return to cmd_ready=1.
  - A new command accepted in that same cycle is legal (back-to-back bursts).
- Reset mid-burst:
  - Abort on the next edge; remaining beats are discarded.
  - Words already written stay in RAM.
  - A pending rd_valid drops without a handshake.
  - No done pulse.

Test Plan:
- Write burst: cmd_we=1, cmd_addr=5, cmd_len=3; wr_data 0xA000..0xA003, wr_valid always 1 → mem_we high for 4 consecutive cycles at mem_addr 5,6,7,8; done pulse one cycle after the last beat; RAM[5..8]=A000..A003.
- Read burst with no stall: after the write above, cmd_we=0, cmd_addr=5, cmd_len=3, rd_ready=1 → rd_data A000, A001, A002, A003, with rd_valid every 3rd cycle; done after the 4th beat.
- Wrap-around: write cmd_addr=62, cmd_len=3 with data 1,2,3,4 → addresses 62, 63, 0, 1; read back from 62 returns 1,2,3,4.
- Read backpressure: rd_ready=0 for 5 cycles on beat 2 → rd_valid stays 1 and rd_data stays stable at the beat-2 value; no extra RAM reads; the sequence resumes correctly.
- Busy/command hold: a second cmd_valid asserted mid-burst → cmd_ready=0 until done; the command is accepted in the done cycle and starts the next cycle.
- Reset mid-burst: rst=1 during beat 2 of a 4-beat write → next cycle IDLE, cmd_ready=1, mem_we=0, no done; RAM holds beats 0–1 only.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Burst controller in front of a single-port synchronous RAM (1-cycle registered read).
// Write beats go straight to the RAM pins; read beats take issue/latency/output cycles each.
module mem_access_ctrl #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_out,
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WRITE    = 3'd1,
    RD_ISSUE = 3'd2,
    RD_LAT   = 3'd3,
    RD_OUT   = 3'd4
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [LEN_WIDTH-1:0]  remaining;

  // Handshakes: a transfer happens on the rising edge where valid && ready are both
  // high; sources hold valid and payload stable until that edge, sinks may drop ready freely.
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  // Gating with rst keeps a beat presented in the reset cycle out of the RAM.
  assign wr_ready  = (state == WRITE) && !rst;
  assign mem_we    = wr_ready && wr_valid;
  assign mem_data  = (state == WRITE) ? wr_data : '0;
  assign mem_addr  = cur_addr;
  assign rd_valid  = (state == RD_OUT);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      rd_data   <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cur_addr  <= cmd_addr;
            remaining <= cmd_len;
            state     <= cmd_we ? WRITE : RD_ISSUE;
          end
        end
        WRITE: begin
          if (wr_valid) begin
            if (remaining == '0) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              remaining <= remaining - 1'b1;
              cur_addr  <= cur_addr + 1'b1;
            end
          end
        end
        RD_ISSUE: state <= RD_LAT;
        RD_LAT: begin
          // RAM sampled cur_addr on the previous edge, so mem_out is valid now.
          rd_data <= mem_out;
          state   <= RD_OUT;
        end
        RD_OUT: begin
          if (rd_ready) begin
            if (remaining == '0) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              remaining <= remaining - 1'b1;
              cur_addr  <= cur_addr + 1'b1;
              state     <= RD_ISSUE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl with a behavioural RAM, write/read scoreboards and a shadow memory.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [5:0]  cmd_addr;
  logic [3:0]  cmd_len;
  logic [15:0] wr_data;
  logic        wr_valid, wr_ready;
  logic [15:0] rd_data;
  logic        rd_valid, rd_ready;
  logic        busy, done;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [15:0] mem_data, mem_out;
  logic [2:0]  state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] exp_q[$];
  logic [21:0] wq[$];
  logic [15:0] shadow[64];
  logic [15:0] ram[64];
  logic        ram_clear;
  logic        done_prev = 1'b0;

  mem_access_ctrl dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .busy(busy), .done(done),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .mem_out(mem_out),
    .state_dbg(state_dbg)
  );

  // Clock and RAM model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < 64; i++) ram[i] <= '0;
      mem_out <= '0;
    end else begin
      if (mem_we) ram[mem_addr] <= mem_data;
      mem_out <= ram[mem_addr];
    end
  end

  function automatic void check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst && !ram_clear) begin
      if (mem_we) begin
        check("wq_nonempty", wq.size() > 0, 1);
        if (wq.size() > 0) begin
          logic [21:0] w;
          w = wq.pop_front();
          check("wr_addr", mem_addr, w[21:16]);
          check("wr_data", mem_data, w[15:0]);
        end
      end
      if (rd_valid && rd_ready) begin
        check("rdq_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("rd_data", rd_data, exp_q.pop_front());
      end
      if (!wr_ready) check("mem_data_idle", mem_data, 0);
      check("done_width", done && done_prev, 0);
      done_prev = done;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Driver tasks; each starts and ends 1 time unit after a rising edge
  task automatic issue_cmd(input logic we, input logic [5:0] a, input logic [3:0] l);
    int n = 0;
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_len = l;
    do begin @(negedge clk); n++; end while (!cmd_ready && n < 50);
    check("cmd_accept", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_we = 1'($urandom); cmd_addr = 6'($urandom); cmd_len = 4'($urandom);
  endtask

  task automatic write_beats(input logic [5:0] a, input logic [3:0] l, input logic [15:0] base, input bit gaps);
    for (int i = 0; i <= int'(l); i++) begin
      logic [5:0]  wa;
      logic [15:0] wd;
      if (gaps) repeat ($urandom_range(0, 2)) begin
        wr_valid = 1'b0; wr_data = 16'($urandom);
        @(posedge clk); #1;
      end
      wa = a + 6'(i);
      wd = base + 16'(i);
      wr_valid = 1'b1; wr_data = wd;
      wq.push_back({wa, wd});
      shadow[wa] = wd;
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    @(negedge clk);
    check("wr_done", done, 1);
    check("wr_done_ready", cmd_ready, 1);
    check("wr_done_busy", busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [5:0] a, input logic [3:0] l, input logic [15:0] base, input bit gaps);
    issue_cmd(1'b1, a, l);
    write_beats(a, l, base, gaps);
  endtask

  task automatic do_read(input logic [5:0] a, input logic [3:0] l, input int stall_beat,
                         input int stall_cyc, input bit hold_next);
    int beats = 0, cyc = 0, left = stall_cyc, last = -10;
    bit got_done = 0;
    logic [5:0] sa;
    sa = a + 6'(stall_beat);
    for (int i = 0; i <= int'(l); i++) exp_q.push_back(shadow[6'(a + 6'(i))]);
    issue_cmd(1'b0, a, l);
    if (hold_next) begin cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 6'd40; cmd_len = 4'd0; end
    while (!got_done && cyc < 300) begin
      rd_ready = !(beats == stall_beat && left > 0);
      @(negedge clk); cyc++;
      if (done) begin
        got_done = 1;
        check("done_ready", cmd_ready, 1);
        check("done_latency", cyc - last, 1);
      end else if (hold_next) check("cmd_hold", cmd_ready, 0);
      if (rd_valid && !rd_ready) begin
        left--;
        check("stall_data", rd_data, shadow[sa]);
        check("stall_addr", mem_addr, sa);
        check("stall_we", mem_we, 0);
      end
      if (rd_valid && rd_ready) begin
        if (stall_beat < 0 && beats > 0) check("rd_spacing", cyc - last, 3);
        last = cyc;
        beats++;
      end
      @(posedge clk); #1;
    end
    rd_ready = 1'b1;
    check("rd_done_seen", got_done, 1);
    check("rd_beats", beats, int'(l) + 1);
  endtask

  initial begin
    rst = 1'b1; ram_clear = 1'b1;
    cmd_valid = 0; cmd_we = 0; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; wr_valid = 0; rd_ready = 1'b1;
    for (int i = 0; i < 64; i++) shadow[i] = '0;
    repeat (3) @(posedge clk);
    #1 ram_clear = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_data", mem_data, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_done", done, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Basic burst write then unstalled read
    do_write(6'd5, 4'd3, 16'hA000, 0);
    do_read(6'd5, 4'd3, -1, 0, 0);

    // Address wrap 62,63,0,1
    do_write(6'd62, 4'd3, 16'd1, 0);
    do_read(6'd62, 4'd3, -1, 0, 0);

    // Read backpressure on the second beat
    do_read(6'd5, 4'd3, 1, 5, 0);

    // Command held while busy, accepted in the done cycle
    do_read(6'd62, 4'd1, -1, 0, 1);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("b2b_busy", busy, 1);
    check("b2b_wr_ready", wr_ready, 1);
    @(posedge clk); #1;
    write_beats(6'd40, 4'd0, 16'h5555, 0);
    do_read(6'd40, 4'd0, -1, 0, 0);

    // Reset during beat 2 of a 4-beat write
    issue_cmd(1'b1, 6'd20, 4'd3);
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1'b1; wr_data = 16'hB000 + 16'(i);
      wq.push_back({6'(20 + i), 16'hB000 + 16'(i)});
      shadow[20 + i] = 16'hB000 + 16'(i);
      @(posedge clk); #1;
    end
    wr_valid = 1'b1; wr_data = 16'hB002; rst = 1'b1;
    @(negedge clk);
    check("rstmid_we", mem_we, 0);
    @(posedge clk); #1;
    rst = 1'b0; wr_valid = 1'b0;
    @(negedge clk);
    check("rstmid_ready", cmd_ready, 1);
    check("rstmid_busy", busy, 0);
    check("rstmid_we2", mem_we, 0);
    check("rstmid_done", done, 0);
    check("rstmid_rd_valid", rd_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rstmid_no_done", done, 0);
    @(posedge clk); #1;
    do_read(6'd20, 4'd3, -1, 0, 0);

    // Random bursts with write gaps and read stalls
    for (int k = 0; k < 6; k++) begin
      logic [5:0]  a;
      logic [3:0]  l;
      logic [15:0] b;
      a = 6'($urandom_range(0, 63));
      l = 4'($urandom_range(0, 7));
      b = 16'($urandom);
      do_write(a, l, b, 1);
      do_read(a, l, $urandom_range(0, int'(l)), $urandom_range(1, 4), 0);
    end

    repeat (3) @(posedge clk);
    check("wq_drained", wq.size(), 0);
    check("rdq_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
